// File: rtl/bspd_pkg.sv
// Shared types and helpers for the round-robin serial pattern detector.
package bspd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Pattern loaded at reset when the instantiating block does not override it.
    localparam logic [3:0] RST_PAT_DEFAULT = 4'b1110;

    // Ceiling log2, never less than 1 so it can size any vector.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/bspd_rr_ctrl_if.sv
// Requester-side word handshake bundle: per-channel valid/data in, one-hot ready out.
interface bspd_rr_ctrl_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    // Front-end side: offers words, sees the accept strobe.
    modport master (output req_valid, output req_data, input req_ready);
    // Controller side: arbitrates and accepts one word at a time.
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/bspd_core.sv
// Serial pattern detector: PW-bit shift history, saturating fill count and
// a comparison against a programmable pattern. match_next reports whether the
// bit currently presented completes a match.
module bspd_core
    import bspd_pkg::*;
#(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          shift_en,
    input  logic          bit_in,
    input  logic [PW-1:0] pattern,
    output logic          match_next
);
    localparam int FW = clog2(PW + 1);

    logic [PW-1:0] hist_reg;
    logic [FW-1:0] fill_reg;
    logic [PW-1:0] hist_next;
    logic [FW-1:0] fill_next;

    // Look-ahead history/fill so the match is known in the cycle the bit arrives.
    always_comb begin
        hist_next  = (hist_reg << 1) | PW'(bit_in);
        fill_next  = (fill_reg >= FW'(PW)) ? fill_reg : fill_reg + FW'(1);
        match_next = shift_en && (fill_next >= FW'(PW)) && (hist_next == pattern);
    end

    // History and fill advance only while shifting; a new word starts empty.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (shift_en) begin
            hist_reg <= hist_next;
            fill_reg <= fill_next;
        end
    end

endmodule

// File: rtl/bspd_rr_ctrl.sv
// Round-robin controller sharing one serial pattern detector among NREQ
// word requesters. One word is granted in IDLE, shifted MSB-first for DW
// cycles, and its hit count is reported in DONE.
module bspd_rr_ctrl
    import bspd_pkg::*;
#(
    parameter int            NREQ    = 4,
    parameter int            DW      = 8,
    parameter int            PW      = 4,
    parameter logic [PW-1:0] RST_PAT = PW'(RST_PAT_DEFAULT)
) (
    input  logic                      clk,
    input  logic                      reset,
    bspd_rr_ctrl_if.slave             req,
    input  logic                      cfg_we,
    input  logic [PW-1:0]             cfg_pattern,
    output logic                      busy,
    output logic                      det_out,
    output logic [clog2(NREQ)-1:0]    det_chan,
    output logic                      done_valid,
    output logic [clog2(DW+1)-1:0]    done_hits
);
    localparam int CW = clog2(NREQ);
    localparam int HW = clog2(DW + 1);
    localparam int IW = clog2(DW);

    state_t        state_reg;
    logic [CW-1:0] last_grant_reg;
    logic [CW-1:0] det_chan_reg;
    logic [DW-1:0] word_reg;
    logic [IW-1:0] bit_idx_reg;
    logic [HW-1:0] hits_reg;
    logic [HW-1:0] done_hits_reg;
    logic          det_out_reg;
    logic          done_valid_reg;
    logic [PW-1:0] pattern_reg;

    logic          grant_valid;
    logic [CW-1:0] grant_idx;
    logic [CW-1:0] arb_idx;
    logic [NREQ-1:0] ready_vec;
    logic [DW-1:0] granted_word;
    logic          match_next;
    logic          last_bit;

    // Round-robin search starting just after the last channel served.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        arb_idx     = '0;
        for (int off = 1; off <= NREQ; off++) begin
            arb_idx = CW'((int'(last_grant_reg) + off) % NREQ);
            if (!grant_valid && req.req_valid[arb_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = arb_idx;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign ready_vec[gi] = (state_reg == IDLE) && grant_valid && (grant_idx == CW'(gi));
    end

    assign req.req_ready = ready_vec;
    assign granted_word  = req.req_data[grant_idx*DW +: DW];
    assign last_bit      = (bit_idx_reg == IW'(DW - 1));

    bspd_core #(.PW(PW)) u_core (
        .clk        (clk),
        .reset      (reset),
        .clr        ((state_reg == IDLE) && grant_valid),
        .shift_en   (state_reg == SHIFT),
        .bit_in     (word_reg[DW-1]),
        .pattern    (pattern_reg),
        .match_next (match_next)
    );

    // Control FSM: grant and capture, shift one bit per cycle, report the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= CW'(NREQ - 1);
            det_chan_reg   <= '0;
            word_reg       <= '0;
            bit_idx_reg    <= '0;
            hits_reg       <= '0;
            done_hits_reg  <= '0;
            det_out_reg    <= 1'b0;
            done_valid_reg <= 1'b0;
            pattern_reg    <= RST_PAT;
        end else begin
            det_out_reg    <= 1'b0;
            done_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cfg_we) begin
                        pattern_reg <= cfg_pattern;
                    end
                    if (grant_valid) begin
                        word_reg     <= granted_word;
                        det_chan_reg <= grant_idx;
                        hits_reg     <= '0;
                        bit_idx_reg  <= '0;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    det_out_reg <= match_next;
                    hits_reg    <= hits_reg + HW'(match_next);
                    word_reg    <= word_reg << 1;
                    bit_idx_reg <= bit_idx_reg + IW'(1);
                    if (last_bit) begin
                        // Final count includes a match on the last bit.
                        done_valid_reg <= 1'b1;
                        done_hits_reg  <= hits_reg + HW'(match_next);
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    last_grant_reg <= det_chan_reg;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy       = (state_reg != IDLE);
    assign det_out    = det_out_reg;
    assign det_chan   = det_chan_reg;
    assign done_valid = done_valid_reg;
    assign done_hits  = done_hits_reg;

endmodule

// File: doc/bspd_rr_ctrl.md
Name: bspd_rr_ctrl

Overview:
- Round-robin controller that shares one programmable serial pattern detector among NREQ parallel-word requesters.
- Grants one requester per word, captures its word, and shifts it MSB-first through the detector one bit per cycle.
- Pulses per-bit detections and reports the per-word hit count, tagged with the channel.
- Sits between word-producing front-ends and the detection/statistics logic.

Parameters:
NREQ, 4, number of requesters (power of two, 2..8)
DW, 8, bits per word
PW, 4, pattern length in bits (PW <= DW)
RST_PAT, 4'b1110, pattern loaded at reset

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-channel word available
req_data  input  NREQ*DW  per-channel word; channel i at bits [i*DW +: DW]
req_ready  output  NREQ  one-hot one-cycle accept strobe
cfg_we  input  1  pattern write strobe
cfg_pattern  input  PW  new pattern; MSB is the first bit of the sequence
busy  output  1  high whenever state != IDLE
det_out  output  1  one-cycle pulse per pattern match
det_chan  output  log2(NREQ)  channel currently being shifted; valid with det_out and done_valid
done_valid  output  1  one-cycle pulse, word finished
done_hits  output  log2(DW+1)  matches found in the finished word

Behaviour:
- Reset values: state IDLE, req_ready 0, det_out 0, done_valid 0, done_hits 0, det_chan 0, busy 0, pattern RST_PAT, last_grant NREQ-1, history and fill count cleared.
- FSM states: IDLE -> SHIFT (DW cycles) -> DONE (1 cycle) -> IDLE. A word occupies DW+2 cycles, giving 1 word per DW+2 cycles at full load.
- IDLE, arbitration:
  - If any req_valid is high, grant the first valid channel searching from last_grant+1 upward, wrapping modulo NREQ.
  - req_ready[g] is high combinationally in that cycle only. The word is captured at that edge.
  - At the same edge: det_chan <= g, history cleared, fill cleared, hits cleared, bit index reset to 0.
  - Next state SHIFT.
- req_ready is never asserted outside IDLE or when the granted channel's req_valid is low.
- SHIFT, per cycle k = 0..DW-1:
  - Presents bit DW-1-k of the captured word.
  - next_hist = {hist[PW-2:0], bit}; fill saturates at PW.
  - match = (fill_next >= PW) and (next_hist == pattern).
  - det_out <= match and hits <= hits + match, both at the same edge.
  - Overlapping matches count.
  - After k = DW-1, go to DONE.
- DONE:
  - done_valid = 1 and done_hits = hits (this already includes a match on the last bit).
  - det_out for the last bit is also high in this cycle if that bit matched.
  - last_grant <= det_chan. Next state IDLE. No grant is made in DONE.
- Latency, with the grant at cycle t: det_out for bit k appears at t+2+k; done_valid appears at t+DW+1.
- History never spans words; no cross-word matches.
- cfg_we:
  - Takes effect only in IDLE cycles. The new pattern applies from the next granted word.
  - Ignored while busy.
  - If cfg_we and a grant happen in the same IDLE cycle, the new pattern is used for that word.
- Reset mid-SHIFT or mid-DONE: the word is abandoned, no done_valid, all registers return to reset values the next cycle, and last_grant returns to NREQ-1.
- A requester that drops req_valid before being granted is simply skipped.
- Unused values of the state encoding return to IDLE.

Decomposition:
- Package bspd_pkg holds: state enum (IDLE, SHIFT, DONE), RST_PAT default, and the clog2 helper for the hit and channel widths.
- One sub-module, bspd_core: PW-bit shift history, fill counter, programmable pattern compare.
  - Inputs: clk, reset, clr, shift_en, bit_in, pattern.
  - Output: match_next (combinational).
- bspd_rr_ctrl holds the arbiter, word register, bit index, hit counter and FSM.

Test Plan:
- Pattern 1110, ch0 sends 0xEE at grant cycle t -> det_out at t+5 and t+9; done_valid at t+9 with done_hits=2 and det_chan=0.
- cfg 1111, ch1 sends 0xFF -> det_out at t+5..t+9 (5 pulses), done_hits=5 (overlap counted).
- Pattern 1110, ch3 sends 0x07 then 0x00 -> done_hits=0 for both words (history cleared between words).
- ch0 and ch2 valid continuously after reset -> grant order 0,2,0,2; req_ready one-hot, one cycle each, grants spaced DW+2=10 cycles apart.
- Assert cfg_we with pattern 0000 during SHIFT of 0xEE -> ignored, done_hits=2. Next word 0x00 after a cfg_we in IDLE -> done_hits=5.
- Assert reset at SHIFT k=4 of ch1 -> no done_valid; busy=0 the next cycle; with ch0 and ch1 both valid, the next grant goes to ch0.
